// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue
//   Ready-valid command buffer placed in front of the ALU input port. It
//   absorbs bursts of {a, b, op} commands while the ALU is busy in a
//   multi-cycle operation and presents them strictly in order. The head entry
//   is shown first-word fall-through. The queue also reports its occupancy
//   and counts the commands issued to the ALU.
//
// Parameters
//   WIDTH  operand width
//   DEPTH  number of entries (power of two, >= 2)
//   CNT_W  width of the issued-command counter (wraps, no saturation)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous reset, active low
//   a_in       producer operand A
//   b_in       producer operand B
//   op_in      producer op (0 = add, 1 = multiply)
//   valid_in   producer command valid
//   ready_out  queue can accept a command
//   a_out      head operand A to ALU
//   b_out      head operand B to ALU
//   op_out     head op to ALU
//   valid_out  head entry valid
//   ready_in   ALU accepts head entry
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   issued     number of completed output handshakes
module alu_cmd_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  input  logic                       op_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic [WIDTH-1:0]           a_out,
  output logic [WIDTH-1:0]           b_out,
  output logic                       op_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           issued
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic             mem_op [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count_r;
  logic [CNT_W-1:0] issued_r;

  logic push;
  logic pop;

  // Both handshake qualifiers come from registered occupancy only, so neither
  // ready depends combinationally on the opposite side. Holding ready_out low
  // while reset is asserted keeps the producer from believing a command was
  // taken during the cycle that discards the queue.
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign ready_out = !full && reset;
  assign valid_out = !empty;

  assign push = valid_in && ready_out;
  assign pop  = valid_out && ready_in;

  // The head is read straight from storage. With the queue empty this still
  // shows the slot at the read pointer, which is stable, and zero after reset
  // because storage is cleared.
  assign a_out  = mem_a[rd_ptr];
  assign b_out  = mem_b[rd_ptr];
  assign op_out = mem_op[rd_ptr];

  assign count  = count_r;
  assign issued = issued_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_r  <= '0;
      issued_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i]  <= '0;
        mem_b[i]  <= '0;
        mem_op[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_a[wr_ptr]  <= a_in;
        mem_b[wr_ptr]  <= b_in;
        mem_op[wr_ptr] <= op_in;
        // DEPTH is a power of two, so natural overflow wraps to 0.
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        issued_r <= issued_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
module tb_alu_cmd_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
  } cmd_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             op_out;
  logic             valid_out;
  logic             ready_in;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] issued;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of accepted commands plus an issue tally.
  cmd_t q[$];
  int   m_issued = 0;

  alu_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .op_in    (op_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .a_out    (a_out),
    .b_out    (b_out),
    .op_out   (op_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .issued   (issued)
  );

  always #5 clk = ~clk;

  // Advance one clock and update the model from the inputs presented at the
  // edge. Returns 1 ns after the edge, where outputs are sampled.
  task automatic tick();
    bit   m_rdy;
    bit   m_vld;
    cmd_t cin;
    m_rdy = (q.size() < DEPTH) && (reset === 1'b1);
    m_vld = (q.size() > 0);
    cin   = {a_in, b_in, op_in};
    @(posedge clk);
    if (reset !== 1'b1) begin
      q.delete();
      m_issued = 0;
    end else begin
      if (m_vld && ready_in) begin
        void'(q.pop_front());
        m_issued++;
      end
      if (m_rdy && valid_in) q.push_back(cin);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
    a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0; op_in = 1'b1;
    tick(); tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready_during got=%b exp=0", ready_out); end
    checks++; if (issued !== '0) begin errors++; $display("FAIL reset_issued got=%0d exp=0", issued); end
    checks++; if ({a_out, b_out, op_out} !== '0) begin errors++; $display("FAIL reset_head got a=%h b=%h op=%b exp all 0", a_out, b_out, op_out); end
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", ready_out); end
  endtask

  task automatic test_single();
    a_in = 32'h3F80_0000; b_in = 32'h4000_0000; op_in = 1'b0;
    valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++; if (valid_out !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL single_visible got valid=%b count=%0d exp valid=1 count=1", valid_out, count); end
    checks++; if (a_out !== 32'h3F80_0000 || b_out !== 32'h4000_0000 || op_out !== 1'b0) begin
      errors++; $display("FAIL single_data got a=%h b=%h op=%b exp a=3f800000 b=40000000 op=0", a_out, b_out, op_out); end
    tick();
    checks++; if (count !== 3'd0 || valid_out !== 1'b0) begin errors++; $display("FAIL single_pop got count=%0d valid=%b exp 0 0", count, valid_out); end
    checks++; if (issued !== 16'd1) begin errors++; $display("FAIL single_issued got=%0d exp=1", issued); end
    ready_in = 1'b0;
  endtask

  task automatic test_fill();
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a_in = $urandom; b_in = $urandom; op_in = i[0]; valid_in = 1'b1;
      tick();
    end
    checks++; if (full !== 1'b1 || ready_out !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL fill_full got full=%b ready=%b count=%0d exp 1 0 4", full, ready_out, count); end
    a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
    tick();
    valid_in = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_rejected got count=%0d exp=4", count); end
    ready_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (valid_out !== 1'b1 || {a_out, b_out, op_out} !== q[0]) begin
        errors++; $display("FAIL fill_order[%0d] got a=%h b=%h op=%b exp a=%h b=%h op=%b", i, a_out, b_out, op_out, q[0].a, q[0].b, q[0].op); end
      tick();
      if (i == 0) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_drop got=%b exp=0", full); end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained got empty=%b exp=1", empty); end
    ready_in = 1'b0;
  endtask

  task automatic test_simul();
    ready_in = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in = $urandom; b_in = $urandom; op_in = i[0];
      tick();
    end
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in = $urandom; b_in = $urandom; op_in = i[0];
      checks++; if ({a_out, b_out, op_out} !== q[0]) begin
        errors++; $display("FAIL simul_order[%0d] got a=%h op=%b exp a=%h op=%b", i, a_out, op_out, q[0].a, q[0].op); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count[%0d] got=%0d exp=2", i, count); end
    end
    valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({a_out, b_out, op_out} !== q[0]) begin
        errors++; $display("FAIL simul_drain[%0d] got a=%h op=%b exp a=%h op=%b", i, a_out, op_out, q[0].a, q[0].op); end
      tick();
    end
    ready_in = 1'b0;
  endtask

  task automatic test_full_pop();
    ready_in = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a_in = $urandom; b_in = $urandom; op_in = i[0];
      tick();
    end
    a_in = 32'hCAFE_0005; b_in = 32'h0000_0005; op_in = 1'b1;
    ready_in = 1'b1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL fullpop_ready got=%b exp=0", ready_out); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_no_push got count=%0d exp=3", count); end
    ready_in = 1'b0;
    tick();
    valid_in = 1'b0;
    checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL fullpop_next_push got count=%0d full=%b exp 4 1", count, full); end
    ready_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++; if (a_out !== 32'hCAFE_0005 || op_out !== 1'b1) begin
          errors++; $display("FAIL fullpop_tail got a=%h op=%b exp a=cafe0005 op=1", a_out, op_out); end
      end else begin
        checks++; if ({a_out, b_out, op_out} !== q[0]) begin
          errors++; $display("FAIL fullpop_order[%0d] got a=%h exp a=%h", i, a_out, q[0].a); end
      end
      tick();
    end
    ready_in = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_a;
    int sent;
    int cyc;
    reset = 1'b0; tick(); reset = 1'b1;
    exp_a = 1; sent = 1; cyc = 0;
    while (exp_a <= 9 && cyc < 200) begin
      a_in = sent; b_in = ~sent; op_in = sent[0];
      valid_in = (sent <= 9);
      ready_in = 1'($urandom_range(0, 1));
      checks++; if (valid_out !== (q.size() > 0)) begin
        errors++; $display("FAIL wrap_valid got=%b exp=%b", valid_out, q.size() > 0); end
      if (q.size() > 0 && ready_in) begin
        checks++; if (a_out !== exp_a) begin errors++; $display("FAIL wrap_order got a=%0d exp=%0d", a_out, exp_a); end
        exp_a++;
      end
      if (valid_in && q.size() < DEPTH) sent++;
      tick();
      cyc++;
    end
    valid_in = 1'b0; ready_in = 1'b0;
    checks++; if (exp_a <= 9) begin errors++; $display("FAIL wrap_timeout got popped=%0d exp=9", exp_a - 1); end
    checks++; if (issued !== 16'd9) begin errors++; $display("FAIL wrap_issued got=%0d exp=9", issued); end
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in = 32'hA000_0000 + i; b_in = $urandom; op_in = i[0];
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre got count=%0d exp=3", count); end
    reset = 1'b0; ready_in = 1'b1;
    #1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rstmid_ready_during got=%b exp=0", ready_out); end
    tick();
    checks++; if (count !== 3'd0 || valid_out !== 1'b0 || issued !== '0) begin
      errors++; $display("FAIL rstmid_cleared got count=%0d valid=%b issued=%0d exp 0 0 0", count, valid_out, issued); end
    reset = 1'b1; valid_in = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got=%b exp=1", ready_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_out !== 1'b0 || issued !== '0) begin
        errors++; $display("FAIL rstmid_no_old[%0d] got valid=%b issued=%0d exp 0 0", i, valid_out, issued); end
    end
    ready_in = 1'b0;
  endtask

  task automatic test_random();
    int thr;
    for (int i = 0; i < 400; i++) begin
      thr = ((i / 50) % 2 == 0) ? 25 : 80;
      valid_in = ($urandom_range(0, 99) < 100 - thr + 10);
      ready_in = ($urandom_range(0, 99) < thr);
      a_in = $urandom; b_in = $urandom; op_in = 1'($urandom);
      checks++; if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_occ[%0d] got count=%0d full=%b empty=%b exp count=%0d", i, count, full, empty, q.size()); end
      checks++; if (valid_out !== (q.size() > 0) || ready_out !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rand_hs[%0d] got valid=%b ready=%b exp size=%0d", i, valid_out, ready_out, q.size()); end
      if (q.size() > 0) begin
        checks++; if ({a_out, b_out, op_out} !== q[0]) begin
          errors++; $display("FAIL rand_head[%0d] got a=%h b=%h op=%b exp a=%h b=%h op=%b", i, a_out, b_out, op_out, q[0].a, q[0].b, q[0].op); end
      end
      checks++; if (issued !== CNT_W'(m_issued)) begin
        errors++; $display("FAIL rand_issued[%0d] got=%0d exp=%0d", i, issued, m_issued); end
      tick();
    end
    valid_in = 1'b0; ready_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    a_in = '0; b_in = '0; op_in = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
